// File: rtl/text_write_ctrl.sv
// -----------------------------------------------------------------------------
// text_write_ctrl
// Accepts a character stream and turns it into writes into a ROWS x COLS text
// RAM. Handles printable characters, newline (0x0A), backspace (0x08) and
// form feed / clear screen (0x0C). RAM writes only happen while the display
// is not reading the RAM (disp = 0); otherwise the controller stalls.
//
// Optional feature: define TEXT_SCROLL_EN to scroll at the bottom row
// (row_offset rotates and the new bottom physical row is blanked). Without
// it the cursor wraps from the last row back to row 0.
//
// Ports
//   CLOCK_50    clock, all state on rising edge
//   resetn      asynchronous active-low reset
//   in_valid    character offered
//   in_char     offered character
//   in_ready    character accepted when in_valid & in_ready (IDLE only)
//   disp        display active, RAM reserved for readout
//   mem_we      text RAM write strobe
//   mem_addr    text RAM address
//   mem_data    text RAM write data
//   cur_col     logical cursor column
//   cur_row     logical cursor row
//   row_offset  physical row holding logical row 0
//   busy        high whenever not IDLE
// -----------------------------------------------------------------------------
module text_write_ctrl #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 60,
    parameter int         COL_W  = 7,
    parameter int         ROW_W  = 6,
    parameter int         ADDR_W = 13,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    input  logic              disp,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
    output logic [ROW_W-1:0]  row_offset,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam logic [COL_W-1:0]  COL_MAX    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX    = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]    ROWS_X     = (ROW_W + 1)'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(ROWS * COLS - 1);

    state_t              state_reg, state_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [ROW_W-1:0]    row_reg, row_next;
    logic [ROW_W-1:0]    offset_reg, offset_next;
    logic [7:0]          char_reg, char_next;
    logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
    logic [ADDR_W-1:0]   clr_last_reg, clr_last_next;
    logic                clr_full_reg, clr_full_next;
    logic                row_adv;

    // Physical address of the cursor. The row sum is one bit wider so that
    // the modulo-ROWS fold is a single conditional subtract.
    logic [ROW_W:0]      row_sum;
    logic [ROW_W-1:0]    phys_row;
    logic [ADDR_W-1:0]   cur_addr;

    assign row_sum  = {1'b0, row_reg} + {1'b0, offset_reg};
    assign phys_row = (row_sum >= ROWS_X) ? ROW_W'(row_sum - ROWS_X) : row_sum[ROW_W-1:0];
    assign cur_addr = ADDR_W'(phys_row) * COLS_A + ADDR_W'(col_reg);

    // State register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            col_reg      <= '0;
            row_reg      <= '0;
            offset_reg   <= '0;
            char_reg     <= '0;
            clr_addr_reg <= '0;
            clr_last_reg <= '0;
            clr_full_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            offset_reg   <= offset_next;
            char_reg     <= char_next;
            clr_addr_reg <= clr_addr_next;
            clr_last_reg <= clr_last_next;
            clr_full_reg <= clr_full_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        offset_next   = offset_reg;
        char_next     = char_reg;
        clr_addr_next = clr_addr_reg;
        clr_last_next = clr_last_reg;
        clr_full_next = clr_full_reg;
        row_adv       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    case (in_char)
                        8'h0A: begin
                            col_next = '0;
                            row_adv  = 1'b1;
                        end
                        8'h08: begin
                            if (col_reg != '0) begin
                                col_next = col_reg - COL_W'(1);
                            end else if (row_reg != '0) begin
                                col_next = COL_MAX;
                                row_next = row_reg - ROW_W'(1);
                            end
                        end
                        8'h0C: begin
                            state_next    = CLEAR;
                            clr_full_next = 1'b1;
                            clr_addr_next = '0;
                            clr_last_next = CELLS_LAST;
                        end
                        default: begin
                            char_next  = in_char;
                            state_next = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (!disp) begin
                    state_next = IDLE;
                    if (col_reg == COL_MAX) begin
                        col_next = '0;
                        row_adv  = 1'b1;
                    end else begin
                        col_next = col_reg + COL_W'(1);
                    end
                end
            end
            CLEAR: begin
                if (!disp) begin
                    if (clr_addr_reg == clr_last_reg) begin
                        state_next = IDLE;
                        if (clr_full_reg) begin
                            col_next    = '0;
                            row_next    = '0;
                            offset_next = '0;
                        end
                    end else begin
                        clr_addr_next = clr_addr_reg + ADDR_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Row advance overrides the state chosen above when a scroll
        // needs a line clear.
        if (row_adv) begin
            if (row_reg != ROW_MAX) begin
                row_next = row_reg + ROW_W'(1);
            end else begin
`ifdef TEXT_SCROLL_EN
                // The old top physical row (old offset) becomes the new
                // bottom row once the offset rotates; blank it.
                offset_next   = (offset_reg == ROW_MAX) ? '0 : offset_reg + ROW_W'(1);
                state_next    = CLEAR;
                clr_full_next = 1'b0;
                clr_addr_next = ADDR_W'(offset_reg) * COLS_A;
                clr_last_next = clr_addr_next + COLS_A - ADDR_W'(1);
`else
                row_next = '0;
`endif
            end
        end
    end

    // Outputs
    always_comb begin
        in_ready = (state_reg == IDLE);
        busy     = (state_reg != IDLE);
        mem_we   = 1'b0;
        mem_addr = cur_addr;
        mem_data = char_reg;
        case (state_reg)
            WRITE: mem_we = !disp;
            CLEAR: begin
                mem_we   = !disp;
                mem_addr = clr_addr_reg;
                mem_data = BLANK;
            end
            default: ;
        endcase
    end

    assign cur_col    = col_reg;
    assign cur_row    = row_reg;
    assign row_offset = offset_reg;

endmodule

// File: tb/tb_text_write_ctrl.sv
module tb_text_write_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam logic [7:0] BLANK = 8'h20;
    localparam int GUARD = 20000;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        disp;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic [5:0]  row_offset;
    logic        busy;

    int err_cnt = 0;
    int chk_cnt = 0;
    int tx_cnt  = 0;

    // Reference model state: logical cursor and scroll offset
    int m_col = 0;
    int m_row = 0;
    int m_off = 0;

    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    text_write_ctrl dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .disp      (disp),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .row_offset(row_offset),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (resetn === 1'b1 && mem_we === 1'b1) begin
            obs_q.push_back({mem_addr, mem_data});
            check("we_while_disp", {31'b0, disp}, 32'd0);
        end
    end

    function automatic int phys(input int r, input int c);
        return ((r + m_off) % ROWS) * COLS + c;
    endfunction

    function automatic logic [31:0] csum(input logic [20:0] q[$]);
        logic [31:0] s = 32'h1234;
        for (int i = 0; i < q.size(); i++)
            s = (s ^ 32'(q[i])) * 32'd31 + 32'(i + 1);
        return s;
    endfunction

    task automatic m_row_adv();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
`ifdef TEXT_SCROLL_EN
            m_off = (m_off + 1) % ROWS;
            for (int c = 0; c < COLS; c++)
                exp_q.push_back({13'(phys(ROWS - 1, c)), BLANK});
`else
            m_row = 0;
`endif
        end
    endtask

    task automatic model_char(input logic [7:0] ch);
        case (ch)
            8'h0A: begin
                m_col = 0;
                m_row_adv();
            end
            8'h08: begin
                if (m_col > 0) m_col--;
                else if (m_row > 0) begin
                    m_col = COLS - 1;
                    m_row--;
                end
            end
            8'h0C: begin
                for (int a = 0; a < ROWS * COLS; a++)
                    exp_q.push_back({13'(a), BLANK});
                m_col = 0;
                m_row = 0;
                m_off = 0;
            end
            default: begin
                exp_q.push_back({13'(phys(m_row, m_col)), ch});
                if (m_col == COLS - 1) begin
                    m_col = 0;
                    m_row_adv();
                end else begin
                    m_col++;
                end
            end
        endcase
    endtask

    // mode 0: disp low; mode 1: disp high for the first 3 busy cycles;
    // mode 2: random disp. Returns the number of busy cycles.
    task automatic send(input logic [7:0] ch, input int mode, output int cyc);
        int guard;
        obs_q.delete();
        exp_q.delete();
        model_char(ch);
        @(posedge CLOCK_50); #1;
        in_valid = 1'b1;
        in_char  = ch;
        disp     = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        in_char  = 8'($urandom);
        cyc   = 0;
        guard = 0;
        while (busy && guard < GUARD) begin
            if (mode == 0)      disp = 1'b0;
            else if (mode == 1) disp = (cyc < 3);
            else                disp = ($urandom_range(0, 3) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_char  = 8'($urandom);
            @(posedge CLOCK_50); #1;
            cyc++;
            guard++;
        end
        in_valid = 1'b0;
        check("timeout_busy", {31'b0, busy}, 32'd0);
        check("nwrites", obs_q.size(), exp_q.size());
        check("write_seq", csum(obs_q), csum(exp_q));
        check("cur_col", cur_col, m_col);
        check("cur_row", cur_row, m_row);
        check("row_offset", row_offset, m_off);
        check("in_ready", {31'b0, in_ready}, 32'd1);
        tx_cnt++;
        $display("tx %0d ch=%02h cycles=%0d writes=%0d col=%0d row=%0d off=%0d",
                 tx_cnt, ch, cyc, obs_q.size(), cur_col, cur_row, row_offset);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50); #2;
        resetn = 1'b0;
        @(posedge CLOCK_50); #1;
        resetn = 1'b1;
        m_col = 0;
        m_row = 0;
        m_off = 0;
    endtask

    initial begin
        int cyc;
        int r;
        logic [7:0] ch;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;
        disp     = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_col", cur_col, 32'd0);
        check("rst_row", cur_row, 32'd0);
        check("rst_off", row_offset, 32'd0);
        resetn = 1'b1;
        @(posedge CLOCK_50); #1;
        check("rst_ready", {31'b0, in_ready}, 32'd1);

        // 'A' with display idle: single-cycle write at address 0
        send(8'h41, 0, cyc);
        check("A_cycles", cyc, 32'd1);
        check("A_write", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFFFFFF, {13'd0, 8'h41});

        // Backspace, including the no-op at 0,0
        send(8'h08, 2, cyc);
        send(8'h08, 2, cyc);

        // 'B' stalled by display, then written once
        do_reset();
        send(8'h42, 1, cyc);
        check("B_cycles", cyc, 32'd4);
        check("B_write", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFFFFFF, {13'd0, 8'h42});

        // Walk to col 79 row 5, then 'Z'
        repeat (5) send(8'h0A, 2, cyc);
        repeat (79) send(8'($urandom_range(33, 126)), 2, cyc);
        send(8'h5A, 2, cyc);
        check("Z_addr", (obs_q.size() > 0) ? 32'(obs_q[0][20:8]) : 32'hFFFF, 32'd479);
        check("Z_col", cur_col, 32'd0);
        check("Z_row", cur_row, 32'd6);

        // Newline at the bottom row
        while (m_row < ROWS - 1) send(8'h0A, 2, cyc);
        send(8'h0A, 2, cyc);
`ifdef TEXT_SCROLL_EN
        check("scroll_off", row_offset, 32'd1);
        check("scroll_row", cur_row, 32'd59);
        check("scroll_writes", obs_q.size(), 32'd80);
`else
        check("wrap_off", row_offset, 32'd0);
        check("wrap_row", cur_row, 32'd0);
        check("wrap_writes", obs_q.size(), 32'd0);
`endif
        repeat (3) send(8'h2E, 2, cyc);
        send(8'h2E, 2, cyc);
        check("col3_addr", (obs_q.size() > 0) ? 32'(obs_q[0][20:8]) : 32'hFFFF, 32'd3);

        // Full clear with display idle
        send(8'h0C, 0, cyc);
        check("clear_cycles", cyc, 32'd4800);
        check("clear_last", (obs_q.size() > 0) ? 32'(obs_q[obs_q.size()-1]) : 32'hFFFFFFFF,
              {13'd4799, BLANK});

        // Reset in the middle of a clear
        @(posedge CLOCK_50); #1;
        in_valid = 1'b1;
        in_char  = 8'h0C;
        disp     = 1'b0;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        repeat (100) @(posedge CLOCK_50);
        #2;
        check("midclr_we_before", {31'b0, mem_we}, 32'd1);
        resetn = 1'b0;
        #1;
        check("midclr_we", {31'b0, mem_we}, 32'd0);
        check("midclr_busy", {31'b0, busy}, 32'd0);
        @(posedge CLOCK_50); #1;
        resetn = 1'b1;
        m_col = 0;
        m_row = 0;
        m_off = 0;
        @(posedge CLOCK_50); #1;
        check("midclr_ready", {31'b0, in_ready}, 32'd1);
        check("midclr_col", cur_col, 32'd0);

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 199);
            if (r < 20)       ch = 8'h0A;
            else if (r < 40)  ch = 8'h08;
            else if (r == 40) ch = 8'h0C;
            else              ch = 8'($urandom_range(32, 126));
            send(ch, 2, cyc);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
